// File: rtl/hardcloud_ctrl_s_axi_gen.sv
// AXI4-Lite control/argument slave with parametrised scalar and pointer banks.
// Define CTRL_SLVERR_EN to answer unmapped accesses with SLVERR.
module hardcloud_ctrl_s_axi_gen #(
    parameter int C_ADDR_WIDTH  = 12,
    parameter int C_DATA_WIDTH  = 32,
    parameter int C_NUM_SCALARS = 2,
    parameter int C_NUM_PTRS    = 2
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic                       awvalid,
    output logic                       awready,
    input  logic [C_ADDR_WIDTH-1:0]    awaddr,
    input  logic                       wvalid,
    output logic                       wready,
    input  logic [C_DATA_WIDTH-1:0]    wdata,
    input  logic [3:0]                 wstrb,
    output logic                       bvalid,
    input  logic                       bready,
    output logic [1:0]                 bresp,
    input  logic                       arvalid,
    output logic                       arready,
    input  logic [C_ADDR_WIDTH-1:0]    araddr,
    output logic                       rvalid,
    input  logic                       rready,
    output logic [C_DATA_WIDTH-1:0]    rdata,
    output logic [1:0]                 rresp,
    output logic                       interrupt,
    output logic                       ap_start,
    input  logic                       ap_ready,
    input  logic                       ap_done,
    input  logic                       ap_idle,
    output logic                       ap_continue,
    output logic [32*C_NUM_SCALARS-1:0] scalars,
    output logic [64*C_NUM_PTRS-1:0]    ptrs
);

`ifdef CTRL_SLVERR_EN
    localparam bit SLVERR_EN = 1'b1;
`else
    localparam bit SLVERR_EN = 1'b0;
`endif

    localparam logic [31:0] SCAL_BASE = 32'h10;
    localparam logic [31:0] PTR_BASE  = SCAL_BASE + 32'(8 * C_NUM_SCALARS);
    localparam logic [31:0] PTR_END   = PTR_BASE + 32'(8 * C_NUM_PTRS);

    typedef enum logic [2:0] {
        K_NONE, K_CTRL, K_GIE, K_IER, K_ISR, K_SCAL, K_PLO, K_PHI
    } kind_t;

    typedef struct packed {
        kind_t      kind;
        logic [5:0] idx;
    } dec_t;

    typedef enum logic [1:0] {
        WR_COLLECT, WR_COMMIT, WR_RESP
    } wr_state_t;

    function automatic dec_t decode(input logic [C_ADDR_WIDTH-1:0] addr);
        logic [31:0] a;
        logic [31:0] off;
        dec_t d;
        d   = '{kind: K_NONE, idx: '0};
        a   = 32'(addr) & 32'hFFFF_FFFC;
        off = '0;
        if (a == 32'h0) begin
            d.kind = K_CTRL;
        end else if (a == 32'h4) begin
            d.kind = K_GIE;
        end else if (a == 32'h8) begin
            d.kind = K_IER;
        end else if (a == 32'hC) begin
            d.kind = K_ISR;
        end else if (a >= SCAL_BASE && a < PTR_BASE) begin
            // the upper word of each 8-byte scalar slot is reserved
            off = a - SCAL_BASE;
            if (!off[2]) begin
                d.kind = K_SCAL;
                d.idx  = 6'(off >> 3);
            end
        end else if (a >= PTR_BASE && a < PTR_END) begin
            off    = a - PTR_BASE;
            d.kind = off[2] ? K_PHI : K_PLO;
            d.idx  = 6'(off >> 3);
        end
        return d;
    endfunction

    function automatic logic [31:0] merge(
        input logic [31:0] old,
        input logic [31:0] data,
        input logic [3:0]  strb
    );
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b+:8] = data[8*b+:8];
        end
        return r;
    endfunction

    wr_state_t state_q, state_d;
    logic      rdy_en;
    logic      aw_held, w_held;
    logic [C_ADDR_WIDTH-1:0] wa_q;
    logic [31:0] wd_q;
    logic [3:0]  ws_q;
    logic        wr_en;
    logic        aw_hs, w_hs, ar_hs;
    dec_t        wdec, rdec;

    logic [C_NUM_SCALARS-1:0][31:0] scal_q;
    logic [C_NUM_PTRS-1:0][63:0]    ptr_q;
    logic        start_q, auto_q, done_q, gie_q;
    logic [1:0]  ier_q, isr_q, isr_set;
    logic        ctrl_wr, isr_wr;
    logic [31:0] rd_val;
    logic        rd_err;

    assign awready = rdy_en && state_q == WR_COLLECT && !aw_held;
    assign wready  = rdy_en && state_q == WR_COLLECT && !w_held;
    assign arready = rdy_en && !rvalid;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign ar_hs   = arvalid && arready;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= WR_COLLECT;
            rdy_en  <= 1'b0;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            wa_q    <= '0;
            wd_q    <= '0;
            ws_q    <= '0;
        end else begin
            state_q <= state_d;
            rdy_en  <= 1'b1;
            if (aw_hs) begin
                aw_held <= 1'b1;
                wa_q    <= awaddr;
            end
            if (w_hs) begin
                w_held <= 1'b1;
                wd_q   <= wdata;
                ws_q   <= wstrb;
            end
            if (state_q == WR_RESP && bready) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        bvalid  = 1'b0;
        unique case (state_q)
            WR_COLLECT: begin
                if ((aw_held || aw_hs) && (w_held || w_hs))
                    state_d = WR_COMMIT;
            end
            WR_COMMIT: begin
                wr_en   = 1'b1;
                state_d = WR_RESP;
            end
            WR_RESP: begin
                bvalid = 1'b1;
                if (bready) state_d = WR_COLLECT;
            end
            default: state_d = WR_COLLECT;
        endcase
    end

    assign wdec    = decode(wa_q);
    assign ctrl_wr = wr_en && wdec.kind == K_CTRL && ws_q[0];
    assign isr_wr  = wr_en && wdec.kind == K_ISR && ws_q[0];
    assign isr_set = ier_q & {ap_ready, ap_done};

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            start_q     <= 1'b0;
            auto_q      <= 1'b0;
            done_q      <= 1'b0;
            gie_q       <= 1'b0;
            ier_q       <= '0;
            isr_q       <= '0;
            ap_continue <= 1'b0;
            bresp       <= 2'b00;
            scal_q      <= '0;
            ptr_q       <= '0;
        end else begin
            // a start request in the same cycle as ap_ready wins
            if (ctrl_wr && wd_q[0])
                start_q <= 1'b1;
            else if (ap_ready && !auto_q)
                start_q <= 1'b0;
            if (ctrl_wr) auto_q <= wd_q[7];
            if (ap_done)
                done_q <= 1'b1;
            else if (ar_hs && rdec.kind == K_CTRL)
                done_q <= 1'b0;
            ap_continue <= (ctrl_wr && wd_q[4]) || (ap_done && auto_q);
            if (wr_en && wdec.kind == K_GIE && ws_q[0]) gie_q <= wd_q[0];
            if (wr_en && wdec.kind == K_IER && ws_q[0]) ier_q <= wd_q[1:0];
            for (int n = 0; n < 2; n++) begin
                if (isr_set[n])
                    isr_q[n] <= 1'b1;
                else if (isr_wr && wd_q[n])
                    isr_q[n] <= ~isr_q[n];
            end
            for (int i = 0; i < C_NUM_SCALARS; i++) begin
                if (wr_en && wdec.kind == K_SCAL && wdec.idx == 6'(i))
                    scal_q[i] <= merge(scal_q[i], wd_q, ws_q);
            end
            for (int j = 0; j < C_NUM_PTRS; j++) begin
                if (wr_en && wdec.kind == K_PLO && wdec.idx == 6'(j))
                    ptr_q[j][31:0] <= merge(ptr_q[j][31:0], wd_q, ws_q);
                if (wr_en && wdec.kind == K_PHI && wdec.idx == 6'(j))
                    ptr_q[j][63:32] <= merge(ptr_q[j][63:32], wd_q, ws_q);
            end
            if (wr_en)
                bresp <= (SLVERR_EN && wdec.kind == K_NONE) ? 2'b10 : 2'b00;
        end
    end

    always_comb begin
        rd_val = '0;
        rdec   = decode(araddr);
        rd_err = rdec.kind == K_NONE;
        unique case (rdec.kind)
            K_CTRL: rd_val = {24'b0, auto_q, 3'b0, ap_ready, ap_idle,
                              done_q, start_q};
            K_GIE:  rd_val = {31'b0, gie_q};
            K_IER:  rd_val = {30'b0, ier_q};
            K_ISR:  rd_val = {30'b0, isr_q};
            K_SCAL: begin
                for (int i = 0; i < C_NUM_SCALARS; i++)
                    if (rdec.idx == 6'(i)) rd_val = scal_q[i];
            end
            K_PLO: begin
                for (int j = 0; j < C_NUM_PTRS; j++)
                    if (rdec.idx == 6'(j)) rd_val = ptr_q[j][31:0];
            end
            K_PHI: begin
                for (int j = 0; j < C_NUM_PTRS; j++)
                    if (rdec.idx == 6'(j)) rd_val = ptr_q[j][63:32];
            end
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            rresp  <= 2'b00;
        end else if (ar_hs) begin
            rvalid <= 1'b1;
            rdata  <= rd_val;
            rresp  <= (SLVERR_EN && rd_err) ? 2'b10 : 2'b00;
        end else if (rvalid && rready) begin
            rvalid <= 1'b0;
        end
    end

    assign ap_start  = start_q;
    assign interrupt = gie_q && (|isr_q);
    assign scalars   = scal_q;
    assign ptrs      = ptr_q;

endmodule

// File: tb/tb_hardcloud_ctrl_s_axi_gen.sv
// Bench for hardcloud_ctrl_s_axi_gen: directed control steps plus random
// argument writes checked against an array model of the register map.
module tb_hardcloud_ctrl_s_axi_gen;
  localparam int NS = 3;
  localparam int NP = 4;
`ifdef CTRL_SLVERR_EN
  localparam logic [1:0] ERR = 2'b10;
`else
  localparam logic [1:0] ERR = 2'b00;
`endif

  logic aclk = 1'b0;
  logic areset = 1'b1;
  logic awvalid, awready, wvalid, wready;
  logic [11:0] awaddr, araddr;
  logic [31:0] wdata, rdata;
  logic [3:0] wstrb;
  logic bvalid, bready, arvalid, arready, rvalid, rready;
  logic [1:0] bresp, rresp;
  logic interrupt, ap_start, ap_ready, ap_done, ap_idle, ap_continue;
  logic [32*NS-1:0] scalars;
  logic [64*NP-1:0] ptrs;

  hardcloud_ctrl_s_axi_gen #(
    .C_ADDR_WIDTH(12), .C_DATA_WIDTH(32),
    .C_NUM_SCALARS(NS), .C_NUM_PTRS(NP)
  ) dut (
    .aclk(aclk), .areset(areset),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .interrupt(interrupt), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_idle(ap_idle), .ap_continue(ap_continue),
    .scalars(scalars), .ptrs(ptrs)
  );

  always #5 aclk = ~aclk;

  int vectors = 0;
  int miscompares = 0;
  int cont_cnt = 0;
  logic [31:0] m_scal [NS];
  logic [63:0] m_ptr [NP];

  always @(posedge aclk) if (ap_continue === 1'b1) cont_cnt <= cont_cnt + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o,
                                        input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b+:8] = d[8*b+:8];
    return r;
  endfunction

  // word w: 0..NS-1 scalars, then pointer low/high pairs
  function automatic logic [11:0] word_addr(input int w);
    if (w < NS) return 12'(16 + 8 * w);
    return 12'(16 + 8 * NS + 8 * ((w - NS) / 2) + 4 * ((w - NS) % 2));
  endfunction

  function automatic logic [31:0] model_word(input int w);
    if (w < NS) return m_scal[w];
    if ((w - NS) % 2 == 0) return m_ptr[(w - NS) / 2][31:0];
    return m_ptr[(w - NS) / 2][63:32];
  endfunction

  task automatic model_write(input int w, input logic [31:0] d,
                             input logic [3:0] s);
    int p;
    p = (w - NS) / 2;
    if (w < NS) m_scal[w] = merge(m_scal[w], d, s);
    else if ((w - NS) % 2 == 0) m_ptr[p][31:0] = merge(m_ptr[p][31:0], d, s);
    else m_ptr[p][63:32] = merge(m_ptr[p][63:32], d, s);
  endtask

  function automatic logic [32*NS-1:0] exp_scal();
    logic [32*NS-1:0] v;
    for (int i = 0; i < NS; i++) v[32*i+:32] = m_scal[i];
    return v;
  endfunction

  function automatic logic [64*NP-1:0] exp_ptr();
    logic [64*NP-1:0] v;
    for (int j = 0; j < NP; j++) v[64*j+:64] = m_ptr[j];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NS; i++) m_scal[i] = '0;
    for (int j = 0; j < NP; j++) m_ptr[j] = '0;
  endtask

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int order,
                           input logic [1:0] exp_resp);
    bit aw_done, w_done, aw_fire, w_fire, got_b;
    logic [1:0] r;
    aw_done = 0; w_done = 0; got_b = 0; r = 2'bxx;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = (order != 2);
    wvalid = (order != 1);
    for (int k = 0; k < 40; k++) begin
      if (aw_done && w_done) break;
      aw_fire = awvalid && awready;
      w_fire = wvalid && wready;
      tick();
      if (aw_fire) begin aw_done = 1; awvalid = 0; end
      if (w_fire) begin w_done = 1; wvalid = 0; end
      if (aw_done && !w_done) wvalid = 1;
      if (w_done && !aw_done) awvalid = 1;
    end
    awvalid = 0; wvalid = 0;
    chk("wr_handshake", {aw_done, w_done}, 2'b11);
    bready = 1;
    for (int k = 0; k < 40; k++) begin
      if (bvalid) begin got_b = 1; r = bresp; tick(); break; end
      tick();
    end
    bready = 0;
    chk("bvalid_seen", got_b, 1'b1);
    chk("bresp", r, exp_resp);
    chk("bvalid_once", bvalid, 1'b0);
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] a,
                        input logic [31:0] exp_d, input logic [1:0] exp_r);
    bit fired;
    fired = 0;
    araddr = a; arvalid = 1;
    for (int k = 0; k < 40; k++) begin
      if (arready) begin fired = 1; tick(); break; end
      tick();
    end
    arvalid = 0;
    chk("ar_handshake", fired, 1'b1);
    chk("rvalid_next", rvalid, 1'b1);
    tick();
    chk("rvalid_hold", rvalid, 1'b1);
    chk(tag, rdata, exp_d);
    chk("rresp", rresp, exp_r);
    rready = 1;
    tick();
    rready = 0;
    chk("rvalid_clear", rvalid, 1'b0);
  endtask

  task automatic pulse_ready();
    ap_ready = 1; tick(); ap_ready = 0;
  endtask

  task automatic pulse_done();
    ap_done = 1; tick(); ap_done = 0;
  endtask

  initial begin
    int c0, w, ord;
    logic [31:0] d;
    logic [3:0] s;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
    ap_ready = 0; ap_done = 0; ap_idle = 1;
    model_reset();

    repeat (2) tick();
    chk("rst_readies", {awready, wready, arready}, 3'b000);
    chk("rst_outs", {ap_start, ap_continue, interrupt, bvalid, rvalid}, 0);
    chk("rst_args", {scalars, ptrs}, 0);
    areset = 0;
    chk("pre_clk_ready", awready, 1'b0);
    tick();
    chk("post_rst_ready", {awready, wready, arready}, 3'b111);
    rd_chk("ctrl_reset", 12'h000, 32'h4, 2'b00);

    awaddr = 12'h010; awvalid = 1;
    tick();
    awvalid = 0;
    chk("aw_held", {awready, wready}, 2'b01);
    areset = 1; tick(); areset = 0; tick();
    chk("rst_mid_write", {awready, wready, bvalid}, 3'b110);
    chk("rst_mid_args", scalars, exp_scal());

    axi_write(12'h018, 32'hDEADBEEF, 4'hF, 2, 2'b00);
    model_write(1, 32'hDEADBEEF, 4'hF);
    chk("scal1_full", scalars[63:32], 32'hDEADBEEF);
    axi_write(12'h018, 32'h12345678, 4'h3, 0, 2'b00);
    model_write(1, 32'h12345678, 4'h3);
    chk("scal1_strb", scalars[63:32], 32'hDEAD5678);
    chk("scal_all", scalars, exp_scal());

    axi_write(12'h030, 32'h11223344, 4'hF, 1, 2'b00);
    model_write(NS + 2, 32'h11223344, 4'hF);
    axi_write(12'h034, 32'h55667788, 4'hF, 0, 2'b00);
    model_write(NS + 3, 32'h55667788, 4'hF);
    chk("ptr1", ptrs[127:64], 64'h5566778811223344);
    rd_chk("ptr1_lo_rd", 12'h030, 32'h11223344, 2'b00);
    rd_chk("ptr1_hi_rd", 12'h034, 32'h55667788, 2'b00);

    axi_write(12'h044, 32'hAAAA5555, 4'hF, 0, 2'b00);
    model_write(NS + 7, 32'hAAAA5555, 4'hF);
    axi_write(12'h048, 32'hFFFFFFFF, 4'hF, 0, ERR);
    axi_write(12'h014, 32'hFFFFFFFF, 4'hF, 2, ERR);
    chk("unmapped_wr_ptrs", ptrs, exp_ptr());
    chk("unmapped_wr_scal", scalars, exp_scal());
    rd_chk("reserved_rd", 12'h014, 32'h0, ERR);
    rd_chk("unmapped_rd", 12'h7F0, 32'h0, ERR);
    rd_chk("past_end_rd", 12'h048, 32'h0, ERR);

    for (int n = 0; n < 24; n++) begin
      w = int'($urandom_range(0, NS + 2 * NP - 1));
      d = $urandom;
      s = 4'($urandom);
      ord = int'($urandom_range(0, 2));
      axi_write(word_addr(w), d, s, ord, 2'b00);
      model_write(w, d, s);
      chk("rand_scal", scalars, exp_scal());
      chk("rand_ptrs", ptrs, exp_ptr());
    end
    for (int n = 0; n < NS + 2 * NP; n++)
      rd_chk("rand_rd", word_addr(n), model_word(n), 2'b00);

    axi_write(12'h000, 32'h1, 4'hE, 0, 2'b00);
    chk("start_no_strb", ap_start, 1'b0);
    axi_write(12'h000, 32'h1, 4'h1, 0, 2'b00);
    chk("start_set", ap_start, 1'b1);
    pulse_ready();
    chk("start_clr", ap_start, 1'b0);

    c0 = cont_cnt;
    axi_write(12'h000, 32'h10, 4'h1, 0, 2'b00);
    tick(); tick();
    chk("continue_wr", cont_cnt - c0, 1);
    chk("continue_no_start", ap_start, 1'b0);

    axi_write(12'h000, 32'h81, 4'h1, 1, 2'b00);
    chk("auto_start", ap_start, 1'b1);
    pulse_ready();
    chk("auto_keep", ap_start, 1'b1);
    c0 = cont_cnt;
    pulse_done();
    tick(); tick();
    chk("continue_auto", cont_cnt - c0, 1);
    rd_chk("ctrl_done", 12'h000, 32'h87, 2'b00);
    rd_chk("ctrl_done_cor", 12'h000, 32'h85, 2'b00);
    axi_write(12'h000, 32'h0, 4'h1, 0, 2'b00);
    chk("zero_keeps_start", ap_start, 1'b1);
    pulse_ready();
    chk("start_clr2", ap_start, 1'b0);

    axi_write(12'h004, 32'h1, 4'h1, 0, 2'b00);
    axi_write(12'h008, 32'h3, 4'h1, 2, 2'b00);
    chk("irq_idle", interrupt, 1'b0);
    pulse_done();
    chk("irq_done", interrupt, 1'b1);
    rd_chk("isr_done", 12'h00C, 32'h1, 2'b00);
    rd_chk("ctrl_irq_done", 12'h000, 32'h6, 2'b00);
    rd_chk("ctrl_irq_cor", 12'h000, 32'h4, 2'b00);
    axi_write(12'h00C, 32'h1, 4'h1, 0, 2'b00);
    chk("irq_cleared", interrupt, 1'b0);
    pulse_ready();
    chk("irq_ready", interrupt, 1'b1);
    rd_chk("isr_ready", 12'h00C, 32'h2, 2'b00);
    axi_write(12'h00C, 32'h2, 4'h1, 0, 2'b00);
    chk("irq_cleared2", interrupt, 1'b0);
    axi_write(12'h004, 32'h0, 4'h1, 0, 2'b00);
    pulse_done();
    chk("irq_gie_off", interrupt, 1'b0);
    rd_chk("isr_gie_off", 12'h00C, 32'h1, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
